// File: rtl/seq_stream_checker.sv
// rtl/seq_stream_checker.sv - receive-side lock/predict checker for the 3-bit state stream
module seq_stream_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 2,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [2:0]       in_state,
   input  logic             in_out,
   input  logic             clr_err,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [2:0]       exp_state,
   output logic [ERR_W-1:0] err_count
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_CHECK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [GW-1:0]    good_cnt;
   logic [GW-1:0]    good_cnt_nxt;
   logic [BW-1:0]    bad_cnt;
   logic [BW-1:0]    bad_cnt_nxt;
   logic [2:0]       exp_nxt;
   logic             err_nxt;
   logic             wrap_nxt;
   logic [ERR_W-1:0] err_count_nxt;

   // Sample qualification terms; HUNT only looks at the parity term.
   logic          parity_ok;
   logic          seq_good;
   logic [GW-1:0] good_cnt_inc;
   logic [BW-1:0] bad_cnt_inc;
   logic          lock_reached;
   logic          loss_reached;
   logic          count_full;

   assign parity_ok    = (in_out == in_state[0]);
   assign seq_good     = parity_ok && (in_state == exp_state);
   assign good_cnt_inc = good_cnt + GW'(1);
   assign bad_cnt_inc  = bad_cnt + BW'(1);
   assign lock_reached = (good_cnt_inc == GW'(LOCK_COUNT));
   assign loss_reached = (bad_cnt_inc == BW'(LOSS_COUNT));
   assign count_full   = &err_count;

   // locked is a pure decode of the registered FSM state.
   assign locked = (state == S_LOCKED);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decision; nothing moves on cycles without a valid sample.
   always_comb begin
      state_nxt = state;
      if (in_valid) begin
         case (state)
            S_HUNT: begin
               if (parity_ok) begin
                  state_nxt = (LOCK_COUNT == 1) ? S_LOCKED : S_CHECK;
               end
            end
            S_CHECK: begin
               if (!seq_good) begin
                  state_nxt = S_HUNT;
               end else if (lock_reached) begin
                  state_nxt = S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (!seq_good && loss_reached) begin
                  state_nxt = S_HUNT;
               end
            end
            default: state_nxt = S_HUNT;
         endcase
      end
   end

   // Next values of prediction, run counters and status pulses.
   always_comb begin
      exp_nxt       = exp_state;
      good_cnt_nxt  = good_cnt;
      bad_cnt_nxt   = bad_cnt;
      err_nxt       = 1'b0;
      wrap_nxt      = 1'b0;
      err_count_nxt = err_count;
      if (in_valid) begin
         case (state)
            S_HUNT: begin
               if (parity_ok) begin
                  exp_nxt      = in_state + 3'd1;
                  good_cnt_nxt = (LOCK_COUNT == 1) ? '0 : GW'(1);
                  bad_cnt_nxt  = '0;
               end
            end
            S_CHECK: begin
               if (seq_good) begin
                  exp_nxt      = exp_state + 3'd1;
                  good_cnt_nxt = lock_reached ? '0 : good_cnt_inc;
                  if (lock_reached) begin
                     bad_cnt_nxt = '0;
                  end
               end else begin
                  good_cnt_nxt = '0;
               end
            end
            S_LOCKED: begin
               // Prediction keeps advancing on errors so a single corrupted
               // sample does not desynchronise the tracker.
               exp_nxt = exp_state + 3'd1;
               if (seq_good) begin
                  bad_cnt_nxt = '0;
                  wrap_nxt    = (in_state == 3'd7);
               end else begin
                  err_nxt     = 1'b1;
                  bad_cnt_nxt = loss_reached ? '0 : bad_cnt_inc;
                  if (!count_full) begin
                     err_count_nxt = err_count + ERR_W'(1);
                  end
               end
            end
            default: begin
               good_cnt_nxt = '0;
               bad_cnt_nxt  = '0;
            end
         endcase
      end
      // Software clear takes precedence over a same-cycle error.
      if (clr_err) begin
         err_count_nxt = '0;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_state <= 3'd0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         err       <= 1'b0;
         wrap      <= 1'b0;
         err_count <= '0;
      end else begin
         exp_state <= exp_nxt;
         good_cnt  <= good_cnt_nxt;
         bad_cnt   <= bad_cnt_nxt;
         err       <= err_nxt;
         wrap      <= wrap_nxt;
         err_count <= err_count_nxt;
      end
   end

endmodule

// File: tb/tb_seq_stream_checker.sv
// tb/tb_seq_stream_checker.sv - scoreboard bench for seq_stream_checker
module tb_seq_stream_checker;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [2:0] in_state;
   logic       in_out;
   logic       clr_err;

   logic       locked_a, err_a, wrap_a;
   logic [2:0] exp_a;
   logic [7:0] cnt_a;
   logic       locked_b, err_b, wrap_b;
   logic [2:0] exp_b;
   logic [1:0] cnt_b;

   seq_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(2), .ERR_W(8)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_state(in_state),
      .in_out(in_out), .clr_err(clr_err), .locked(locked_a), .err(err_a),
      .wrap(wrap_a), .exp_state(exp_a), .err_count(cnt_a)
   );

   seq_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_state(in_state),
      .in_out(in_out), .clr_err(clr_err), .locked(locked_b), .err(err_b),
      .wrap(wrap_b), .exp_state(exp_b), .err_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int st;
      int g;
      int b;
      int expv;
      int cnt;
      int err;
      int wrap;
   } mdl_t;

   typedef struct {
      int locked;
      int err;
      int wrap;
      int expv;
      int cnt;
   } obs_t;

   mdl_t ma, mb;
   obs_t qa[$];
   obs_t qb[$];
   int checks = 0;
   int errors = 0;
   logic [2:0] sp;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.st = 0; r.g = 0; r.b = 0; r.expv = 0; r.cnt = 0; r.err = 0; r.wrap = 0;
      return r;
   endfunction

   // Reference behaviour: 0=HUNT 1=CHECK 2=LOCKED.
   function automatic mdl_t step(input mdl_t m, input int lock_n, input int loss_n,
                                 input int cmax, input bit rst, input bit v,
                                 input int s, input bit o, input bit clr);
      mdl_t r;
      bit par;
      bit hit;
      r = m;
      r.err = 0;
      r.wrap = 0;
      if (rst) return mdl_reset();
      par = (o == s[0]);
      hit = par && (s == m.expv);
      if (v) begin
         if (m.st == 0) begin
            if (par) begin
               r.expv = (s + 1) % 8;
               r.g = 1;
               r.b = 0;
               if (lock_n == 1) begin r.st = 2; r.g = 0; end
               else r.st = 1;
            end
         end else if (m.st == 1) begin
            if (hit) begin
               r.expv = (m.expv + 1) % 8;
               r.g = m.g + 1;
               if (r.g == lock_n) begin r.st = 2; r.g = 0; r.b = 0; end
            end else begin
               r.st = 0;
               r.g = 0;
            end
         end else begin
            r.expv = (m.expv + 1) % 8;
            if (hit) begin
               r.b = 0;
               r.wrap = (s == 7) ? 1 : 0;
            end else begin
               r.err = 1;
               if (m.cnt < cmax) r.cnt = m.cnt + 1;
               r.b = m.b + 1;
               if (r.b == loss_n) begin r.st = 0; r.b = 0; end
            end
         end
      end
      if (clr) r.cnt = 0;
      return r;
   endfunction

   function automatic obs_t view(input mdl_t m);
      obs_t o;
      o.locked = (m.st == 2) ? 1 : 0;
      o.err = m.err;
      o.wrap = m.wrap;
      o.expv = m.expv;
      o.cnt = m.cnt;
      return o;
   endfunction

   task automatic score();
      obs_t e;
      if (qa.size() == 0 || qb.size() == 0) begin
         check("queue_empty", 0, 1);
      end else begin
         e = qa.pop_front();
         check("a_locked", int'(locked_a), e.locked);
         check("a_err", int'(err_a), e.err);
         check("a_wrap", int'(wrap_a), e.wrap);
         check("a_exp_state", int'(exp_a), e.expv);
         check("a_err_count", int'(cnt_a), e.cnt);
         e = qb.pop_front();
         check("b_locked", int'(locked_b), e.locked);
         check("b_err", int'(err_b), e.err);
         check("b_wrap", int'(wrap_b), e.wrap);
         check("b_exp_state", int'(exp_b), e.expv);
         check("b_err_count", int'(cnt_b), e.cnt);
      end
   endtask

   task automatic drive(input bit rst, input bit v, input logic [2:0] s,
                        input bit o, input bit clr);
      reset = rst;
      in_valid = v;
      in_state = s;
      in_out = o;
      clr_err = clr;
      ma = step(ma, 4, 2, 255, rst, v, int'(s), o, clr);
      mb = step(mb, 4, 8, 3, rst, v, int'(s), o, clr);
      qa.push_back(view(ma));
      qb.push_back(view(mb));
      @(posedge clk);
      #1;
      score();
   endtask

   task automatic good();
      drive(1'b0, 1'b1, sp, sp[0], 1'b0);
      sp = sp + 3'd1;
   endtask

   task automatic bad();
      drive(1'b0, 1'b1, sp, ~sp[0], 1'b0);
      sp = sp + 3'd1;
   endtask

   initial begin
      int wraps;
      int errs;
      bit v;
      bit o;
      bit clr;
      bit rst;
      logic [2:0] hold;
      reset = 1'b1;
      in_valid = 1'b0;
      in_state = 3'd0;
      in_out = 1'b0;
      clr_err = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();

      // Reset values
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      check("rst_locked", int'(locked_a), 0);
      check("rst_exp_state", int'(exp_a), 0);
      check("rst_err_count", int'(cnt_a), 0);

      // Clean stream 0..7,0
      sp = 3'd0;
      wraps = 0;
      errs = 0;
      for (int i = 0; i < 9; i++) begin
         good();
         wraps += int'(wrap_a);
         errs += int'(err_a);
         if (i == 2) check("t1_not_locked_3rd", int'(locked_a), 0);
         if (i == 3) check("t1_locked_4th", int'(locked_a), 1);
      end
      check("t1_wrap_once", wraps, 1);
      check("t1_no_err", errs, 0);
      check("t1_exp_end", int'(exp_a), 1);

      // Single error while locked
      for (int i = 0; i < 3; i++) good();
      bad();
      check("t2_err", int'(err_a), 1);
      check("t2_err_count", int'(cnt_a), 1);
      check("t2_still_locked", int'(locked_a), 1);
      good();
      check("t2_no_err_after", int'(err_a), 0);

      // Two consecutive errors drop lock, then relock
      bad();
      check("t3_locked_after_1", int'(locked_a), 1);
      bad();
      check("t3_err_2nd", int'(err_a), 1);
      check("t3_unlocked", int'(locked_a), 0);
      check("t3_err_count", int'(cnt_a), 3);
      for (int i = 0; i < 4; i++) begin
         good();
         if (i == 2) check("t3_relock_pending", int'(locked_a), 0);
      end
      check("t3_relocked", int'(locked_a), 1);

      // Gapped valid
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      sp = 3'd2;
      for (int i = 0; i < 4; i++) begin
         good();
         hold = exp_a;
         drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
         check("t4_exp_hold", int'(exp_a), int'(hold));
         if (i == 2) check("t4_not_locked", int'(locked_a), 0);
      end
      check("t4_locked", int'(locked_a), 1);

      // Saturation on a narrow counter and clear precedence
      drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      sp = 3'd0;
      for (int i = 0; i < 4; i++) good();
      for (int i = 0; i < 5; i++) begin
         bad();
         good();
      end
      check("t5_b_saturated", int'(cnt_b), 3);
      check("t5_b_locked", int'(locked_b), 1);
      check("t5_a_count", int'(cnt_a), 5);
      drive(1'b0, 1'b1, sp, ~sp[0], 1'b1);
      sp = sp + 3'd1;
      check("t5_clr_err_pulse", int'(err_b), 1);
      check("t5_clr_wins", int'(cnt_b), 0);

      // Reset mid-lock
      good();
      for (int i = 0; i < 5; i++) begin
         bad();
         good();
      end
      check("t6_pre_count", int'(cnt_a), 5);
      check("t6_pre_locked", int'(locked_a), 1);
      drive(1'b1, 1'b1, sp, sp[0], 1'b0);
      check("t6_locked", int'(locked_a), 0);
      check("t6_err_count", int'(cnt_a), 0);
      check("t6_exp_state", int'(exp_a), 0);

      // Random mixed traffic against the model
      sp = 3'd0;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         o = sp[0];
         if ($urandom_range(0, 7) == 0) o = ~o;
         if ($urandom_range(0, 15) == 0) sp = 3'($urandom_range(0, 7));
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 99) == 0);
         drive(rst, v, sp, o, clr);
         if (v) sp = sp + 3'd1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
